// File: rtl/noc_conf_responder.sv
// noc_conf_responder: answers configuration query packets on a dedicated NoC
// channel with the tile's static system configuration, either as a full dump
// of all config words or as one selected word.
module noc_conf_responder #(
  parameter int unsigned   TILEID         = 0,
  parameter int unsigned   NUMCTS         = 4,
  parameter logic [1023:0] CTLIST         = {
    16'd63, 16'd62, 16'd61, 16'd60, 16'd59, 16'd58, 16'd57, 16'd56,
    16'd55, 16'd54, 16'd53, 16'd52, 16'd51, 16'd50, 16'd49, 16'd48,
    16'd47, 16'd46, 16'd45, 16'd44, 16'd43, 16'd42, 16'd41, 16'd40,
    16'd39, 16'd38, 16'd37, 16'd36, 16'd35, 16'd34, 16'd33, 16'd32,
    16'd31, 16'd30, 16'd29, 16'd28, 16'd27, 16'd26, 16'd25, 16'd24,
    16'd23, 16'd22, 16'd21, 16'd20, 16'd19, 16'd18, 16'd17, 16'd16,
    16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10, 16'd9,  16'd8,
    16'd7,  16'd6,  16'd5,  16'd4,  16'd3,  16'd2,  16'd1,  16'd0},
  parameter int unsigned   CORES_PER_TILE = 1,
  parameter logic [31:0]   GMEM_SIZE      = 32'h0,
  parameter int unsigned   GMEM_TILE      = 0,
  parameter logic [31:0]   LMEM_SIZE      = 32'h8000,
  parameter logic          MEMORY_ACCESS  = 1'b0,
  parameter logic          USE_DEBUG      = 1'b0,
  parameter logic          DEBUG_STM      = 1'b1,
  parameter logic          DEBUG_CTM      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_flit,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_flit,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  // Two CTLIST entries are packed per word after the five fixed words.
  localparam int unsigned NWORDS   = 5 + (NUMCTS + 1) / 2;
  localparam logic [7:0]  NW8      = 8'(NWORDS);
  localparam logic [7:0]  LAST_PTR = NW8 - 8'd1;
  localparam logic [15:0] TILE16   = 16'(TILEID);
  localparam logic [4:0]  TILE5    = 5'(TILEID);
  localparam logic [6:0]  NCT7     = 7'(NUMCTS);

  typedef enum logic [1:0] {IDLE, DRAIN, HDR, DATA} state_t;

  state_t      state, state_nxt;
  logic [4:0]  req_src;
  logic [2:0]  req_class;
  logic        req_mode;
  logic [7:0]  req_index;
  logic [7:0]  ptr;

  logic [31:0] word;
  logic [31:0] header;
  logic        data_last;
  logic [4:0]  pair_idx;
  logic [5:0]  lo_sel;
  logic [5:0]  hi_sel;
  logic [15:0] ct_lo;
  logic [15:0] ct_hi;

  // Header bits that carry nothing for this endpoint (destination, reserved).
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{in_flit[31:27], in_flit[18:16], in_flit[14:8]};

  // Config word selected by ptr; indexes past the last word read as zero.
  always_comb begin
    pair_idx = 5'(ptr - 8'd5);
    lo_sel   = {pair_idx, 1'b0};
    hi_sel   = {pair_idx, 1'b1};
    ct_lo    = CTLIST[{lo_sel, 4'b0000} +: 16];
    ct_hi    = ({1'b0, hi_sel} < NCT7) ? CTLIST[{hi_sel, 4'b0000} +: 16] : 16'h0;
    word     = 32'h0;
    case (ptr)
      8'd0:    word = {16'h0001, TILE16};
      8'd1:    word = {16'(NUMCTS), 16'(CORES_PER_TILE)};
      8'd2:    word = GMEM_SIZE;
      8'd3:    word = {16'(GMEM_TILE), 12'b0, DEBUG_CTM, DEBUG_STM, USE_DEBUG, MEMORY_ACCESS};
      8'd4:    word = LMEM_SIZE;
      default: word = (ptr < NW8) ? {ct_hi, ct_lo} : 32'h0;
    endcase
  end

  // Response header and the end-of-packet marker for the data phase.
  always_comb begin
    header    = {req_src, req_class, TILE5, 3'b000, (req_mode ? 16'd1 : 16'(NWORDS))};
    data_last = req_mode | (ptr == LAST_PTR);
  end

  // State register plus request fields captured on header acceptance and the
  // word pointer that walks the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_src   <= 5'h0;
      req_class <= 3'h0;
      req_mode  <= 1'b0;
      req_index <= 8'h0;
      ptr       <= 8'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        req_src   <= in_flit[23:19];
        req_class <= in_flit[26:24];
        req_mode  <= in_flit[15];
        req_index <= in_flit[7:0];
      end
      if (state == HDR && out_ready) begin
        ptr <= in_flit[15] & 1'b0 | (req_mode ? req_index : 8'd0);
      end else if (state == DATA && out_ready) begin
        ptr <= ptr + 8'd1;
      end
    end
  end

  // Next state and handshake outputs; reset forces all outputs low.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_flit  = 32'h0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? HDR : DRAIN;
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = HDR;
      end
      HDR: begin
        out_valid = 1'b1;
        out_flit  = header;
        if (out_ready) state_nxt = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_flit  = word;
        out_last  = data_last;
        if (out_ready && data_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_flit  = 32'h0;
    end
  end

endmodule

// File: tb/tb_noc_conf_responder.sv
// tb_noc_conf_responder: two responder instances (even and odd compute-tile
// counts) driven with directed and random requests, checked every cycle
// against a packet-level model of the expected response stream.
module tb_noc_conf_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][31:0] in_flit = '0;
  logic [1:0] in_last = '0;
  logic [1:0] in_valid = '0;
  logic [1:0] out_ready = '0;
  logic [1:0] rand_ready = '0;
  wire  [1:0][31:0] out_flit;
  wire  [1:0] in_ready;
  wire  [1:0] out_valid;
  wire  [1:0] out_last;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [32:0] expq [2][$];
  logic [32:0] cap [2][$];
  int          capcyc [2][$];
  logic        req_open [2];
  logic [31:0] m_hdr [2];
  logic        prev_stall [2];
  logic [32:0] held [2];

  localparam logic [32:0] DUMP0 [8] = '{
    33'h0_28100007, 33'h0_00010002, 33'h0_00040001, 33'h0_10000000,
    33'h0_0007000B, 33'h0_00008000, 33'h0_00010000, 33'h1_00030002};
  localparam logic [32:0] DUMP1 [8] = '{
    33'h0_28480007, 33'h0_00010009, 33'h0_00030002, 33'h0_00000000,
    33'h0_0000000C, 33'h0_00008000, 33'h0_00050004, 33'h1_00000006};

  always #5 clk = ~clk;

  noc_conf_responder #(
    .TILEID(2), .NUMCTS(4), .CORES_PER_TILE(1), .GMEM_SIZE(32'h1000_0000),
    .GMEM_TILE(7), .LMEM_SIZE(32'h8000), .MEMORY_ACCESS(1'b1),
    .USE_DEBUG(1'b1), .DEBUG_STM(1'b0), .DEBUG_CTM(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .in_flit(in_flit[0]), .in_last(in_last[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_flit(out_flit[0]),
    .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  noc_conf_responder #(
    .TILEID(9), .NUMCTS(3), .CTLIST({976'b0, 16'd6, 16'd5, 16'd4}),
    .CORES_PER_TILE(2), .GMEM_SIZE(32'h0), .GMEM_TILE(0), .LMEM_SIZE(32'h8000),
    .MEMORY_ACCESS(1'b0), .USE_DEBUG(1'b0), .DEBUG_STM(1'b1), .DEBUG_CTM(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_flit(in_flit[1]), .in_last(in_last[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_flit(out_flit[1]),
    .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  // Configuration each instance was built with.
  function automatic int cfg_nct(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [31:0] cfg_tile(input int d);
    return (d == 0) ? 32'd2 : 32'd9;
  endfunction

  function automatic logic [15:0] ct_entry(input int d, input int e);
    if (d == 0) return 16'(e);
    return (e < 3) ? 16'(e + 4) : 16'h0;
  endfunction

  function automatic int nwords(input int d);
    return 5 + (cfg_nct(d) + 1) / 2;
  endfunction

  // Config word i as software would read it from tile d.
  function automatic logic [31:0] model_word(input int d, input int i);
    logic [31:0] t, c, gsz, gt, lsz;
    logic ma, ud, stm, ctm;
    int nct, e;
    nct = cfg_nct(d);
    t = cfg_tile(d);
    if (d == 0) begin
      c = 1; gsz = 32'h1000_0000; gt = 7; lsz = 32'h8000;
      ma = 1; ud = 1; stm = 0; ctm = 1;
    end else begin
      c = 2; gsz = 0; gt = 0; lsz = 32'h8000;
      ma = 0; ud = 0; stm = 1; ctm = 1;
    end
    if (i >= nwords(d)) return 32'h0;
    e = 2 * (i - 5);
    case (i)
      0: return {16'h0001, t[15:0]};
      1: return {16'(nct), c[15:0]};
      2: return gsz;
      3: return {gt[15:0], 12'b0, ctm, stm, ud, ma};
      4: return lsz;
      default: return {((e + 1 < nct) ? ct_entry(d, e + 1) : 16'h0), ct_entry(d, e)};
    endcase
  endfunction

  // Queue the full response a completed request must produce.
  function automatic void pushExpected(input int d, input logic [31:0] h);
    logic [31:0] t;
    int n, cnt;
    t = cfg_tile(d);
    n = nwords(d);
    cnt = h[15] ? 1 : n;
    expq[d].push_back({1'b0, h[23:19], h[26:24], t[4:0], 3'b000, 16'(cnt)});
    if (h[15]) begin
      expq[d].push_back({1'b1, model_word(d, int'(h[7:0]))});
    end else begin
      for (int i = 0; i < n; i++) expq[d].push_back({(i == n - 1), model_word(d, i)});
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Send one request of nflits flits to instance d, optionally with idle gaps.
  task automatic applyStimulus(input int d, input logic [31:0] hdr, input int nflits,
                               input bit gaps, output int acc_cyc);
    bit acc;
    int guard;
    for (int i = 0; i < nflits; i++) begin
      if (gaps && i > 0) begin
        in_valid[d] = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_flit[d]  = (i == 0) ? hdr : $urandom;
      in_last[d]  = (i == nflits - 1);
      in_valid[d] = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready[d];
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 2000) begin
          checkOutput($sformatf("in_accept_timeout_d%0d", d), 0, 1);
          acc = 1'b1;
        end
      end
    end
    acc_cyc = cyc;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic waitIdle(input int d);
    int guard = 0;
    while ((expq[d].size() != 0 || out_valid[d]) && guard <= 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard > 3000) checkOutput($sformatf("response_timeout_d%0d", d), 0, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sink readiness: always high, or random per instance when stalling is enabled.
  initial forever begin
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) out_ready[d] = rand_ready[d] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Per-cycle compare against the model, plus request monitoring.
  initial begin
    for (int d = 0; d < 2; d++) begin req_open[d] = 0; prev_stall[d] = 0; held[d] = '0; m_hdr[d] = '0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          checkOutput($sformatf("reset_outputs_d%0d", d),
                      {in_ready[d], out_valid[d], out_last[d], out_flit[d]}, '0);
          expq[d].delete();
          req_open[d] = 0;
          prev_stall[d] = 0;
        end else begin
          checkOutput($sformatf("in_ready_d%0d", d), in_ready[d], expq[d].size() == 0);
          checkOutput($sformatf("out_valid_d%0d", d), out_valid[d], expq[d].size() != 0);
          if (prev_stall[d])
            checkOutput($sformatf("stall_hold_d%0d", d),
                        {out_valid[d], out_last[d], out_flit[d]}, {1'b1, held[d]});
          if (out_valid[d] && expq[d].size() != 0) begin
            checkOutput($sformatf("flit_d%0d", d), {out_last[d], out_flit[d]}, expq[d][0]);
            if (out_ready[d]) begin
              void'(expq[d].pop_front());
              cap[d].push_back({out_last[d], out_flit[d]});
              capcyc[d].push_back(cyc + 1);
              prev_stall[d] = 0;
            end else begin
              prev_stall[d] = 1;
              held[d] = {out_last[d], out_flit[d]};
            end
          end else begin
            prev_stall[d] = 0;
          end
          if (in_valid[d] && in_ready[d]) begin
            if (!req_open[d]) begin m_hdr[d] = in_flit[d]; req_open[d] = 1; end
            if (in_last[d]) begin pushExpected(d, m_hdr[d]); req_open[d] = 0; end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    checkOutput("global_timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a random request mix.
  initial begin
    int acc, guard, n;
    logic [32:0] ref_run [$];
    logic [31:0] hdr;
    logic [31:0] sw_hdr [3];
    logic [32:0] sw_data [3];

    rst = 1'b1;
    in_valid = 2'b11;
    in_flit[0] = 32'h00280000;
    in_flit[1] = 32'h00280000;
    in_last = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 2'b00;
    in_last = 2'b00;
    @(negedge clk);
    checkOutput("in_ready_after_reset_d0", in_ready[0], 1);
    checkOutput("in_ready_after_reset_d1", in_ready[1], 1);
    @(posedge clk); #1;

    $display("[TB] full dump, even tile count");
    cap[0].delete(); capcyc[0].delete();
    applyStimulus(0, 32'h00280000, 1, 0, acc);
    waitIdle(0);
    checkOutput("dump0_len", cap[0].size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap[0].size()) begin
        checkOutput($sformatf("dump0_flit%0d", i), cap[0][i], DUMP0[i]);
        checkOutput($sformatf("dump0_cycle%0d", i), capcyc[0][i], acc + 1 + i);
      end
    end

    $display("[TB] single-word reads");
    sw_hdr[0] = 32'h00288001; sw_data[0] = 33'h1_00040001;
    sw_hdr[1] = 32'h00288009; sw_data[1] = 33'h1_00000000;
    sw_hdr[2] = 32'h002880FF; sw_data[2] = 33'h1_00000000;
    for (int k = 0; k < 3; k++) begin
      cap[0].delete(); capcyc[0].delete();
      applyStimulus(0, sw_hdr[k], 1, 0, acc);
      waitIdle(0);
      checkOutput($sformatf("single%0d_len", k), cap[0].size(), 2);
      if (cap[0].size() >= 2) begin
        checkOutput($sformatf("single%0d_hdr", k), cap[0][0], 33'h0_28100001);
        checkOutput($sformatf("single%0d_data", k), cap[0][1], sw_data[k]);
      end
    end

    $display("[TB] back-pressure on a 3-flit request");
    cap[0].delete(); capcyc[0].delete();
    applyStimulus(0, 32'hF3A00002, 3, 0, acc);
    waitIdle(0);
    ref_run = cap[0];
    rand_ready[0] = 1'b1;
    cap[0].delete(); capcyc[0].delete();
    applyStimulus(0, 32'hF3A00002, 3, 1, acc);
    waitIdle(0);
    rand_ready[0] = 1'b0;
    checkOutput("bp_len", cap[0].size(), 8);
    if (cap[0].size() > 0) checkOutput("bp_hdr", cap[0][0], 33'h0_A3100007);
    for (int i = 0; i < 8; i++) begin
      if (i < cap[0].size() && i < ref_run.size())
        checkOutput($sformatf("bp_same%0d", i), cap[0][i], ref_run[i]);
    end

    $display("[TB] full dump, odd tile count");
    cap[1].delete(); capcyc[1].delete();
    applyStimulus(1, 32'h00280000, 1, 0, acc);
    waitIdle(1);
    checkOutput("dump1_len", cap[1].size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap[1].size()) checkOutput($sformatf("dump1_flit%0d", i), cap[1][i], DUMP1[i]);
    end

    $display("[TB] reset in the middle of a response");
    cap[0].delete(); capcyc[0].delete();
    applyStimulus(0, 32'h00280000, 1, 0, acc);
    guard = 0;
    while (cap[0].size() < 3 && guard < 100) begin @(posedge clk); #1; guard++; end
    checkOutput("midrst_progress", cap[0].size(), 3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cap[0].delete(); capcyc[0].delete();
    applyStimulus(0, 32'h00280000, 1, 0, acc);
    waitIdle(0);
    checkOutput("midrst_redo_len", cap[0].size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap[0].size()) checkOutput($sformatf("midrst_redo%0d", i), cap[0][i], DUMP0[i]);
    end

    $display("[TB] random requests");
    rand_ready = 2'b11;
    for (int r = 0; r < 40; r++) begin
      int d;
      d = $urandom_range(0, 1);
      hdr = $urandom;
      hdr[15] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) hdr[7:0] = 8'($urandom_range(0, 12));
      n = $urandom_range(1, 4);
      applyStimulus(d, hdr, n, 1, acc);
      waitIdle(d);
    end
    rand_ready = 2'b00;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
